fetch_stage: RTL and testbench

Instruction fetch stage of the single-issue core. It owns the program counter, issues requests to instruction memory over a request/grant/response handshake, and holds the fetched word in an instruction register. It presents the decoded opcode[6:2], func3 and func7 fields to the control unit, and advances or redirects the PC when the current instruction retires. While no valid instruction is held, the outputs carry a NOP so downstream control decodes a harmless op.

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the single-issue core. Owns the program counter,
// issues one instruction-memory request at a time over a request/grant/response
// handshake and holds the returned word until the consumer retires it. While
// nothing is held, the instruction outputs carry NOP_INST so that downstream
// control decodes a harmless operation.
//
// Parameters
//   RESET_PC     first fetch address after reset (word aligned)
//   NOP_INST     word presented while no instruction is held
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous, active-low reset
//   imem_req     fetch request, held until granted
//   imem_addr    fetch address, stable while imem_req=1
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   inst         held instruction word (NOP_INST when inst_valid=0)
//   opcode       inst[6:2]
//   func3        inst[14:12]
//   func7        inst[31:25]
//   pc           address of the held instruction
//   pc_p4        pc + 4, wrapping
//   inst_valid   inst holds a fetched word
//   retire       consumer finished the held instruction
//   stall        consumer busy; blocks retire
//   redirect     taken branch/jump, only honoured with an accepted retire
//   target       redirect address, low two bits forced to zero
//   retired_cnt  number of accepted retires, wrapping
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] pc,
  output logic [31:0] pc_p4,
  output logic        inst_valid,
  input  logic        retire,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retired_cnt;

  logic        w_accept;
  logic        w_capture;
  logic        w_imem_req;
  logic        w_inst_valid;
  logic [31:0] w_pc_p4;
  logic [31:0] w_redir_pc;

  // A retire only counts in HOLD and while the consumer is not stalled.
  assign w_accept   = (r_state == S_HOLD) && retire && !stall;
  // Responses outside WAIT (reset, IDLE, REQ) are dropped.
  assign w_capture  = (r_state == S_WAIT) && imem_rvalid;
  assign w_pc_p4    = r_pc + 32'd4;
  assign w_redir_pc = target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_imem_req   = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_imem_req = 1'b1;
        if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_inst_valid = 1'b1;
        if (w_accept) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_pc          <= RESET_PC;
      r_inst        <= NOP_INST;
      r_retired_cnt <= 32'd0;
    end else begin
      if (w_capture) begin
        r_inst <= imem_rdata;
        r_pc   <= r_fetch_pc;
      end
      if (w_accept) begin
        r_fetch_pc    <= redirect ? w_redir_pc : w_pc_p4;
        r_retired_cnt <= r_retired_cnt + 32'd1;
        // Drop back to the NOP so nothing stale is decoded during the refetch.
        r_inst        <= NOP_INST;
      end
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_fetch_pc;
  assign inst        = r_inst;
  assign opcode      = r_inst[6:2];
  assign func3       = r_inst[14:12];
  assign func7       = r_inst[31:25];
  assign pc          = r_pc;
  assign pc_p4       = w_pc_p4;
  assign inst_valid  = w_inst_valid;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        retire = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'd0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc;
  logic [31:0] pc_p4;
  logic        inst_valid;
  logic [31:0] retired_cnt;

  logic        w_req_w;
  logic [31:0] w_addr_w;
  logic [31:0] w_inst_w;
  logic [4:0]  w_opcode_w;
  logic [2:0]  w_func3_w;
  logic [6:0]  w_func7_w;
  logic [31:0] w_pc_w;
  logic [31:0] w_pc_p4_w;
  logic        w_valid_w;
  logic [31:0] w_cnt_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .opcode(opcode), .func3(func3), .func7(func7),
    .pc(pc), .pc_p4(pc_p4), .inst_valid(inst_valid),
    .retire(retire), .stall(stall), .redirect(redirect), .target(target),
    .retired_cnt(retired_cnt)
  );

  // Second instance starting at the top of the address space; shares stimulus.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req_w), .imem_addr(w_addr_w), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(w_inst_w), .opcode(w_opcode_w), .func3(w_func3_w), .func7(w_func7_w),
    .pc(w_pc_w), .pc_p4(w_pc_p4_w), .inst_valid(w_valid_w),
    .retire(retire), .stall(stall), .redirect(redirect), .target(target),
    .retired_cnt(w_cnt_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one fetch transaction in flight, tracked as
  // "requesting", "waiting for data" or "holding a word".
  bit          m_seen = 1'b0;
  bit          m_booting = 1'b1;
  bit          m_requesting = 1'b0;
  bit          m_waiting = 1'b0;
  bit          m_holding = 1'b0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_cnt = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_booting = 1'b1; m_requesting = 1'b0; m_waiting = 1'b0; m_holding = 1'b0;
      m_fetch = 32'd0; m_pc = 32'd0; m_word = 32'd0; m_cnt = 32'd0;
    end else if (m_booting) begin
      m_booting = 1'b0;
      m_requesting = 1'b1;
    end else if (m_requesting) begin
      if (imem_gnt) begin m_requesting = 1'b0; m_waiting = 1'b1; end
    end else if (m_waiting) begin
      if (imem_rvalid) begin
        m_word = imem_rdata; m_pc = m_fetch;
        m_waiting = 1'b0; m_holding = 1'b1;
      end
    end else if (m_holding && retire && !stall) begin
      m_fetch = redirect ? {target[31:2], 2'b00} : m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      m_holding = 1'b0; m_requesting = 1'b1;
    end
    if (clk) m_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (m_seen) begin
      logic [31:0] e_inst;
      e_inst = m_holding ? m_word : NOP;
      chk("m_imem_req", imem_req, m_requesting);
      chk("m_imem_addr", imem_addr, m_fetch);
      chk("m_inst", inst, e_inst);
      chk("m_opcode", opcode, e_inst[6:2]);
      chk("m_func3", func3, e_inst[14:12]);
      chk("m_func7", func7, e_inst[31:25]);
      chk("m_pc", pc, m_pc);
      chk("m_pc_p4", pc_p4, m_pc + 32'd4);
      chk("m_inst_valid", inst_valid, m_holding);
      chk("m_retired_cnt", retired_cnt, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(); cyc();
    // Reset state
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", inst_valid, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_pc", pc, 0);
    chk("rst_wrap_addr", w_addr_w, 32'hFFFF_FFFC);

    rst = 1'b1;
    cyc();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);

    // A response while requesting is ignored
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    cyc();
    imem_rvalid = 1'b0;
    chk("req_ignores_rvalid", imem_req, 1);
    chk("req_ignores_rvalid_v", inst_valid, 0);

    // Immediate grant, response one cycle later
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    chk("wait_req_low", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; cyc(); imem_rvalid = 1'b0;
    chk("t1_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_opcode", opcode, 5'b00100);
    chk("t1_func3", func3, 0);
    chk("t1_func7", func7, 0);
    chk("t1_pc", pc, 0);
    chk("t1_pc_p4", pc_p4, 4);
    chk("wrap_pc", w_pc_w, 32'hFFFF_FFFC);
    chk("wrap_pc_p4", w_pc_p4_w, 0);

    // Sequential retire, retire held high throughout
    retire = 1'b1; cyc();
    chk("t2_req", imem_req, 1);
    chk("t2_addr", imem_addr, 4);
    chk("t2_cnt", retired_cnt, 1);
    chk("t2_inst_nop", inst, NOP);
    chk("wrap_next_addr", w_addr_w, 32'h0);
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113; cyc(); imem_rvalid = 1'b0;
    chk("t2_pc", pc, 4);
    chk("t2_valid", inst_valid, 1);
    cyc();
    chk("t2_cnt2", retired_cnt, 2);
    chk("t2_addr2", imem_addr, 8);
    chk("t2_req2", imem_req, 1);
    retire = 1'b0;

    // sra x10,x10,x11 then a redirect
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h40B5_5533; cyc(); imem_rvalid = 1'b0;
    chk("t3_opcode", opcode, 5'b01100);
    chk("t3_func3", func3, 3'd5);
    chk("t3_func7", func7, 7'h20);
    chk("t3_pc", pc, 8);
    retire = 1'b1; redirect = 1'b1; target = 32'h0000_0123;
    cyc();
    retire = 1'b0; redirect = 1'b0;
    chk("t3_redir_addr", imem_addr, 32'h0000_0120);
    chk("t3_cnt", retired_cnt, 3);

    // Grant held off four cycles
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("gnt_delay_req", imem_req, 1);
      chk("gnt_delay_addr", imem_addr, 32'h0000_0120);
    end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    cyc(); cyc();
    chk("late_rvalid_valid", inst_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_8093; cyc(); imem_rvalid = 1'b0;
    chk("t3_pc_after", pc, 32'h0000_0120);
    chk("t3_pc_p4_after", pc_p4, 32'h0000_0124);

    // Stall blocks retire; redirect without an accepted retire is ignored
    retire = 1'b1; stall = 1'b1; redirect = 1'b1; target = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      cyc();
      redirect = 1'b0;
      chk("stall_req", imem_req, 0);
      chk("stall_pc", pc, 32'h0000_0120);
      chk("stall_cnt", retired_cnt, 3);
    end
    stall = 1'b0; cyc(); retire = 1'b0;
    chk("unstall_cnt", retired_cnt, 4);
    chk("unstall_addr", imem_addr, 32'h0000_0124);
    chk("unstall_req", imem_req, 1);

    // Reset in the middle of a fetch, with a late response
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    rst = 1'b0; #1;
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_cnt", retired_cnt, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("midrst_inst", inst, NOP);
    chk("midrst_valid", inst_valid, 0);
    rst = 1'b1;
    cyc();
    imem_rvalid = 1'b0;
    chk("postrst_inst", inst, NOP);
    chk("postrst_valid", inst_valid, 0);
    chk("postrst_req", imem_req, 1);
    chk("postrst_addr", imem_addr, 32'h0);

    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; cyc(); imem_rvalid = 1'b0;
    chk("postrst_fetch_inst", inst, 32'h0050_0093);
    retire = 1'b1; cyc(); retire = 1'b0;
    chk("postrst_cnt", retired_cnt, 1);
    chk("postrst_next_addr", imem_addr, 4);

    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
